pixel_histogram: RTL

Frame histogram accumulator directly downstream of the MIPI D-PHY to CMOS bridge in the camera FPGA. Consumes the parallel pixel bus (pixel data, frame valid, line valid) in the pixel clock domain and bins every active pixel by its most-significant bits. Uses two ping-pong counter banks: one bank accumulates the current frame while the other streams the completed histogram out over a valid/ready interface to the host link.

---
 rtl/histo_pkg.sv | 26 ++
 rtl/histo_bank.sv | 48 ++++
 rtl/pixel_histogram.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/histo_pkg.sv
// histo_pkg: default widths, bin-count derivation, dump FSM state type and the
// trailer enable. Optional feature macro: HISTO_TOTAL_EN (per-frame pixel total
// appended as a trailer word after the last bin).
package histo_pkg;

    localparam int unsigned PIX_W_DEF    = 10;
    localparam int unsigned BIN_BITS_DEF = 6;
    localparam int unsigned COUNT_W_DEF  = 20;

    // Number of histogram bins addressed by a bin index of the given width.
    function automatic int unsigned calc_nbins(input int unsigned bin_bits);
        return 32'd1 << bin_bits;
    endfunction

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StDump = 1'b1
    } histo_state_e;

`ifdef HISTO_TOTAL_EN
    localparam bit TOTAL_EN = 1'b1;
`else
    localparam bit TOTAL_EN = 1'b0;
`endif

endpackage

// File: rtl/histo_bank.sv
// histo_bank: one histogram counter bank. Flop array of saturating counters with
// an increment port, a read-and-clear port and a single-cycle bulk clear.
module histo_bank
    import histo_pkg::*;
#(
    parameter int unsigned BIN_BITS = BIN_BITS_DEF,
    parameter int unsigned COUNT_W  = COUNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc_en,
    input  logic [BIN_BITS-1:0] inc_bin,
    input  logic                rd_clr,
    input  logic [BIN_BITS-1:0] rd_idx,
    input  logic                bulk_clr,
    output logic [COUNT_W-1:0]  rd_data
);

    localparam int unsigned NBINS = calc_nbins(BIN_BITS);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;
    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

    logic [COUNT_W-1:0] cnt_q [NBINS];

    // Counter array: bulk clear wins; otherwise read-clear and saturating increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NBINS); i++) begin
                cnt_q[i] <= '0;
            end
        end else if (bulk_clr) begin
            for (int i = 0; i < int'(NBINS); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            if (rd_clr) begin
                cnt_q[rd_idx] <= '0;
            end
            // Direct read of the flop makes back-to-back same-bin hits safe.
            if (inc_en && (cnt_q[inc_bin] != CNT_MAX)) begin
                cnt_q[inc_bin] <= cnt_q[inc_bin] + CNT_ONE;
            end
        end
    end

    assign rd_data = cnt_q[rd_idx];

endmodule

// File: rtl/pixel_histogram.sv
// pixel_histogram: frame histogram of the parallel pixel bus using two ping-pong
// banks; one accumulates, the other is streamed out over valid/ready.
// Optional feature macro: HISTO_TOTAL_EN (trailer word carrying the frame's
// active pixel total, saturated into COUNT_W).
module pixel_histogram
    import histo_pkg::*;
#(
    parameter int unsigned PIX_W    = PIX_W_DEF,
    parameter int unsigned BIN_BITS = BIN_BITS_DEF,
    parameter int unsigned COUNT_W  = COUNT_W_DEF
) (
    input  logic                clk_pixel_i,
    input  logic                reset_n_i,
    input  logic [PIX_W-1:0]    pd_i,
    input  logic                fv_i,
    input  logic                lv_i,
    output logic [COUNT_W-1:0]  hist_data_o,
    output logic [BIN_BITS-1:0] hist_bin_o,
    output logic                hist_valid_o,
    input  logic                hist_ready_i,
    output logic                hist_last_o,
    output logic [7:0]          frame_cnt_o,
    output logic                frame_drop_o
);

    localparam int unsigned NBINS = calc_nbins(BIN_BITS);
    localparam logic [BIN_BITS-1:0] LAST_BIN = BIN_BITS'(NBINS - 1);
    localparam logic [BIN_BITS-1:0] BIN_ONE  = BIN_BITS'(1);

    logic                fv_q, eof_q, s1_valid_q;
    logic [BIN_BITS-1:0] s1_bin_q;

    histo_state_e        state_q, state_d;
    logic [BIN_BITS-1:0] rd_idx_q, rd_idx_d;
    logic                trl_q, trl_d;
    logic                acc_sel_q, acc_sel_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;
    logic                drop_q, drop_d;

    logic                swap, bulk_clr, rd_clr;
    logic [COUNT_W-1:0]  rd_data0, rd_data1, dump_data, total_word;

    logic                unused_pd;
    assign unused_pd = ^pd_i[PIX_W-BIN_BITS-1:0];

    // Stage 1: register bin index and active flag; detect falling frame valid.
    always_ff @(posedge clk_pixel_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fv_q       <= 1'b0;
            eof_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_bin_q   <= '0;
        end else begin
            fv_q       <= fv_i;
            eof_q      <= fv_q & ~fv_i;
            s1_valid_q <= fv_i & lv_i;
            s1_bin_q   <= pd_i[PIX_W-1 -: BIN_BITS];
        end
    end

    // Dump FSM and bank-select state registers.
    always_ff @(posedge clk_pixel_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= StIdle;
            rd_idx_q    <= '0;
            trl_q       <= 1'b0;
            acc_sel_q   <= 1'b0;
            frame_cnt_q <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_idx_q    <= rd_idx_d;
            trl_q       <= trl_d;
            acc_sel_q   <= acc_sel_d;
            frame_cnt_q <= frame_cnt_d;
            drop_q      <= drop_d;
        end
    end

    // Next state: swap banks on EOF when idle, drop the frame when busy, walk bins.
    always_comb begin
        state_d     = state_q;
        rd_idx_d    = rd_idx_q;
        trl_d       = trl_q;
        acc_sel_d   = acc_sel_q;
        frame_cnt_d = frame_cnt_q;
        drop_d      = 1'b0;
        swap        = 1'b0;
        bulk_clr    = 1'b0;
        rd_clr      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (eof_q) begin
                    swap        = 1'b1;
                    state_d     = StDump;
                    acc_sel_d   = ~acc_sel_q;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    rd_idx_d    = '0;
                    trl_d       = 1'b0;
                end
            end
            StDump: begin
                // Finished frame cannot be handed over: discard it in place.
                if (eof_q) begin
                    bulk_clr = 1'b1;
                    drop_d   = 1'b1;
                end
                if (hist_ready_i) begin
                    if (trl_q) begin
                        trl_d   = 1'b0;
                        state_d = StIdle;
                    end else begin
                        rd_clr = 1'b1;
                        if (rd_idx_q == LAST_BIN) begin
                            if (TOTAL_EN) begin
                                trl_d = 1'b1;
                            end else begin
                                state_d = StIdle;
                            end
                        end else begin
                            rd_idx_d = rd_idx_q + BIN_ONE;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    histo_bank #(
        .BIN_BITS (BIN_BITS),
        .COUNT_W  (COUNT_W)
    ) u_bank0 (
        .clk      (clk_pixel_i),
        .rst_n    (reset_n_i),
        .inc_en   (s1_valid_q & ~acc_sel_q),
        .inc_bin  (s1_bin_q),
        .rd_clr   (rd_clr & acc_sel_q),
        .rd_idx   (rd_idx_q),
        .bulk_clr (bulk_clr & ~acc_sel_q),
        .rd_data  (rd_data0)
    );

    histo_bank #(
        .BIN_BITS (BIN_BITS),
        .COUNT_W  (COUNT_W)
    ) u_bank1 (
        .clk      (clk_pixel_i),
        .rst_n    (reset_n_i),
        .inc_en   (s1_valid_q & acc_sel_q),
        .inc_bin  (s1_bin_q),
        .rd_clr   (rd_clr & ~acc_sel_q),
        .rd_idx   (rd_idx_q),
        .bulk_clr (bulk_clr & acc_sel_q),
        .rd_data  (rd_data1)
    );

    assign dump_data = acc_sel_q ? rd_data0 : rd_data1;

`ifdef HISTO_TOTAL_EN
    logic [31:0] acc_total_q, dump_total_q, acc_total_inc;

    assign acc_total_inc = (s1_valid_q && (acc_total_q != '1)) ? acc_total_q + 32'd1
                                                               : acc_total_q;

    // Active pixel total follows the banks: handed over on swap, cleared on drop.
    always_ff @(posedge clk_pixel_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            acc_total_q  <= '0;
            dump_total_q <= '0;
        end else if (swap) begin
            dump_total_q <= acc_total_inc;
            acc_total_q  <= '0;
        end else if (bulk_clr) begin
            acc_total_q  <= '0;
        end else begin
            acc_total_q  <= acc_total_inc;
        end
    end

    assign total_word = (|dump_total_q[31:COUNT_W]) ? '1 : dump_total_q[COUNT_W-1:0];
`else
    assign total_word = '0;
`endif

    assign hist_valid_o = (state_q == StDump);
    assign hist_data_o  = !hist_valid_o ? '0 : (trl_q ? total_word : dump_data);
    assign hist_bin_o   = (hist_valid_o && !trl_q) ? rd_idx_q : '0;
    assign hist_last_o  = hist_valid_o && (TOTAL_EN ? trl_q : (rd_idx_q == LAST_BIN));
    assign frame_cnt_o  = frame_cnt_q;
    assign frame_drop_o = drop_q;

endmodule
